cla_add_arbiter: RTL and testbench

Round-robin front-end that shares one pipelined 32-bit CLA adder (`cla_32bit`) between `NREQ` requesters. It accepts one operand pair per cycle and registers the operands into the adder. It carries a valid/requester-ID tag alongside the adder's fixed-latency pipeline and returns each 33-bit result on a shared, registered response bus. Per-requester in-flight counters cap outstanding operations; there is no response backpressure.

---
 rtl/cla_pkg.sv | 12 +
 rtl/cla_add_arbiter_if.sv | 18 +
 rtl/cla_32bit.sv | 41 ++++
 rtl/rr_arbiter.sv | 36 +++
 rtl/cla_add_arbiter.sv | 109 ++++++++++
 tb/tb_cla_add_arbiter.sv | 179 +++++++++++++++++
 6 files changed

// File: rtl/cla_pkg.sv
// Shared types and widths for the CLA adder and its round-robin front-end.
package cla_pkg;
   localparam int OP_W            = 32;
   localparam int SUM_W           = 33;
   localparam int ADD_LAT_DEFAULT = 6;
   localparam int ID_W            = 3;   // covers up to 8 requesters

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } cla_tag_t;
endpackage

// File: rtl/cla_add_arbiter_if.sv
// Request/response bundle between requesters and the shared adder front-end.
interface cla_add_arbiter_if import cla_pkg::*; #(parameter int NREQ = 4);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]           i_req_valid;
   logic [NREQ-1:0][OP_W-1:0] i_req_a;
   logic [NREQ-1:0][OP_W-1:0] i_req_b;
   logic [NREQ-1:0]           o_req_ready;
   logic                      o_rsp_valid;
   logic [IDW-1:0]            o_rsp_id;
   logic [SUM_W-1:0]          o_rsp_sum;
   logic                      o_busy;

   modport master (output i_req_valid, i_req_a, i_req_b,
                   input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_sum, o_busy);
   modport slave  (input  i_req_valid, i_req_a, i_req_b,
                   output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_sum, o_busy);
endinterface

// File: rtl/cla_32bit.sv
// 32-bit carry-lookahead adder (4-bit groups) followed by a LAT-deep result pipeline.
module cla_32bit import cla_pkg::*; #(
   parameter int LAT = ADD_LAT_DEFAULT
) (
   input  logic             i_clk,
   input  logic [OP_W-1:0]  i_a,
   input  logic [OP_W-1:0]  i_b,
   output logic [SUM_W-1:0] o_out
);
   logic [OP_W-1:0]           g, p;
   logic [OP_W:0]             c;
   logic [7:0]                gg, gp;
   logic [SUM_W-1:0]          res;
   logic [LAT-1:0][SUM_W-1:0] pipe_q;

   always_comb begin
      g  = i_a & i_b;
      p  = i_a ^ i_b;
      gg = '0;
      gp = '0;
      c  = '0;
      for (int n = 0; n < 8; n++) begin
         gg[n] = g[4*n+3] | (p[4*n+3] & g[4*n+2]) | (p[4*n+3] & p[4*n+2] & g[4*n+1])
               | (p[4*n+3] & p[4*n+2] & p[4*n+1] & g[4*n]);
         gp[n] = &p[4*n +: 4];
      end
      // group carries first, then the carries inside each group
      for (int n = 0; n < 8; n++) c[4*(n+1)] = gg[n] | (gp[n] & c[4*n]);
      for (int n = 0; n < 8; n++)
         for (int j = 0; j < 3; j++) c[4*n+j+1] = g[4*n+j] | (p[4*n+j] & c[4*n+j]);
      res = {c[OP_W], p ^ c[OP_W-1:0]};
   end

   // datapath flops carry no reset; the tag pipeline decides what is valid
   always_ff @(posedge i_clk) begin
      pipe_q[0] <= res;
      for (int s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
   end

   assign o_out = pipe_q[LAT-1];
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; pointer advances only when i_adv is high.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_adv,
   output logic [NREQ-1:0] o_gnt
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW-1:0] last_q, last_d, idx, sel;
   logic           found;

   always_comb begin
      o_gnt  = '0;
      idx    = '0;
      sel    = '0;
      found  = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IDW'((int'(last_q) + i) % NREQ);
         if (!found && i_req[idx]) begin
            o_gnt[idx] = 1'b1;
            sel        = idx;
            found      = 1'b1;
         end
      end
      last_d = (i_adv && found) ? sel : last_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) last_q <= IDW'(NREQ - 1);
      else          last_q <= last_d;
   end
endmodule

// File: rtl/cla_add_arbiter.sv
// Shares one pipelined CLA adder among NREQ requesters with per-requester in-flight caps.
module cla_add_arbiter import cla_pkg::*; #(
   parameter int NREQ    = 4,
   parameter int ADD_LAT = ADD_LAT_DEFAULT,
   parameter int MAX_OUT = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   cla_add_arbiter_if.slave   bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]            elig, gnt;
   logic [NREQ-1:0][3:0]       infl_q, infl_d;
   logic [OP_W-1:0]            sel_a, sel_b, op_a_q, op_b_q;
   logic [ID_W-1:0]            sel_id;
   cla_tag_t                   op_tag_q;
   cla_tag_t [ADD_LAT-1:0]     tag_q;
   logic [SUM_W-1:0]           add_out, rsp_sum_q;
   logic                       rsp_vld_q, tag_busy;
   logic [IDW-1:0]             rsp_id_q;

   // ready must read 0 while reset is held, even with valid asserted
   always_comb begin
      elig = '0;
      for (int k = 0; k < NREQ; k++)
         elig[k] = i_rst_n && bus.i_req_valid[k] && (infl_q[k] < 4'(MAX_OUT));
   end

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (elig),
      .i_adv   (|gnt),
      .o_gnt   (gnt)
   );

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_id = '0;
      for (int k = 0; k < NREQ; k++)
         if (gnt[k]) begin
            sel_a  = bus.i_req_a[k];
            sel_b  = bus.i_req_b[k];
            sel_id = ID_W'(k);
         end
   end

   always_comb begin
      infl_d = infl_q;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k] && !(rsp_vld_q && rsp_id_q == IDW'(k)))
            infl_d[k] = infl_q[k] + 4'd1;
         else if (!gnt[k] && rsp_vld_q && rsp_id_q == IDW'(k) && infl_q[k] != 4'd0)
            infl_d[k] = infl_q[k] - 4'd1;
      end
   end

   // idle cycles load zeros so the adder does not toggle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_a_q   <= '0;
         op_b_q   <= '0;
         op_tag_q <= '0;
      end else begin
         op_a_q   <= sel_a;
         op_b_q   <= sel_b;
         op_tag_q <= '{vld: |gnt, id: sel_id};
      end
   end

   cla_32bit #(.LAT(ADD_LAT)) u_add (
      .i_clk (i_clk),
      .i_a   (op_a_q),
      .i_b   (op_b_q),
      .o_out (add_out)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tag_q     <= '0;
         rsp_vld_q <= 1'b0;
         rsp_id_q  <= '0;
         rsp_sum_q <= '0;
         infl_q    <= '0;
      end else begin
         tag_q[0] <= op_tag_q;
         for (int s = 1; s < ADD_LAT; s++) tag_q[s] <= tag_q[s-1];
         rsp_vld_q <= tag_q[ADD_LAT-1].vld;
         if (tag_q[ADD_LAT-1].vld) begin
            rsp_id_q  <= tag_q[ADD_LAT-1].id[IDW-1:0];
            rsp_sum_q <= add_out;
         end
         infl_q <= infl_d;
      end
   end

   always_comb begin
      tag_busy = 1'b0;
      for (int s = 0; s < ADD_LAT; s++) tag_busy = tag_busy | tag_q[s].vld;
   end

   assign bus.o_req_ready = gnt;
   assign bus.o_rsp_valid = rsp_vld_q;
   assign bus.o_rsp_id    = rsp_id_q;
   assign bus.o_rsp_sum   = rsp_sum_q;
   assign bus.o_busy      = op_tag_q.vld | tag_busy | rsp_vld_q;
endmodule

// File: tb/tb_cla_add_arbiter.sv
// Scoreboard bench: driver predicts grants and results, monitor checks each response pulse.
module tb_cla_add_arbiter;
   import cla_pkg::*;
   localparam int N = 4, LAT = 6, MAXO = 4, RLAT = LAT + 2;

   typedef struct {
      int          id;
      logic [32:0] sum;
      int          due;
   } exp_t;

   logic i_clk = 1'b0;
   logic i_rst_n;

   cla_add_arbiter_if #(.NREQ(N)) bus_if();

   cla_add_arbiter #(.NREQ(N), .ADD_LAT(LAT), .MAX_OUT(MAXO)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus_if)
   );

   always #5 i_clk = ~i_clk;

   exp_t sb[$];
   int   due_q[N][$];
   int   cyc = 0, checks = 0, errors = 0, last = N - 1;

   always @(posedge i_clk) cyc <= cyc + 1;

   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // outstanding ops for k: issued and not yet past their response cycle
   function automatic int infl(input int k);
      int n = 0;
      for (int j = 0; j < due_q[k].size(); j++) if (due_q[k][j] >= cyc) n++;
      return n;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic do_cycle(input logic [N-1:0] v, input logic [N-1:0][31:0] a,
                           input logic [N-1:0][31:0] b);
      int g, idx;
      logic [N-1:0] expg;
      bus_if.i_req_valid = v;
      bus_if.i_req_a     = a;
      bus_if.i_req_b     = b;
      @(negedge i_clk);
      expg = '0;
      g    = -1;
      for (int i = 1; i <= N; i++) begin
         idx = (last + i) % N;
         if (g < 0 && v[idx] && infl(idx) < MAXO) g = idx;
      end
      if (g >= 0) expg[g] = 1'b1;
      checks++;
      if (bus_if.o_req_ready !== expg) begin
         errors++;
         $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, bus_if.o_req_ready, expg);
      end
      if (g >= 0) begin
         sb.push_back(exp_t'{g, ref_add(a[g], b[g]), cyc + RLAT});
         due_q[g].push_back(cyc + RLAT);
         last = g;
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic rnd_cycle(input logic [N-1:0] v);
      logic [N-1:0][31:0] a, b;
      for (int k = 0; k < N; k++) begin
         a[k] = $urandom();
         b[k] = $urandom();
      end
      do_cycle(v, a, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle('0, '0, '0);
   endtask

   always @(negedge i_clk) begin
      exp_t e;
      if (i_rst_n === 1'b1 && bus_if.o_rsp_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp cyc=%0d id=%0d sum=%h", cyc, bus_if.o_rsp_id, bus_if.o_rsp_sum);
         end else begin
            e = sb.pop_front();
            if (bus_if.o_rsp_id !== 2'(e.id) || bus_if.o_rsp_sum !== e.sum || cyc != e.due) begin
               errors++;
               $display("FAIL rsp got id=%0d sum=%h cyc=%0d exp id=%0d sum=%h cyc=%0d",
                        bus_if.o_rsp_id, bus_if.o_rsp_sum, cyc, e.id, e.sum, e.due);
            end
         end
      end
   end

   initial begin
      logic [N-1:0][31:0] a, b;
      i_rst_n            = 1'b0;
      bus_if.i_req_valid = '0;
      bus_if.i_req_a     = '0;
      bus_if.i_req_b     = '0;
      #1;
      chk("rst_ready", 64'(bus_if.o_req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus_if.o_rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(bus_if.o_rsp_id), 64'd0);
      chk("rst_rsp_sum", 64'(bus_if.o_rsp_sum), 64'd0);
      chk("rst_busy", 64'(bus_if.o_busy), 64'd0);
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;

      // single request from requester 2
      a = '0; b = '0;
      a[2] = 32'h0000_FFFF; b[2] = 32'h0000_0001;
      do_cycle(4'b0100, a, b);
      idle(10);

      // all four requesting continuously
      for (int i = 0; i < 16; i++) rnd_cycle(4'b1111);
      idle(10);

      // single requester against the in-flight cap
      for (int i = 0; i < 30; i++) rnd_cycle(4'b0001);
      idle(10);

      // carry out of bit 31
      a = '0; b = '0;
      a[1] = 32'hFFFF_FFFF; b[1] = 32'h0000_0001;
      do_cycle(4'b0010, a, b);
      a[1] = '0; b[1] = '0;
      a[3] = 32'hFFFF_FFFF; b[3] = 32'hFFFF_FFFF;
      do_cycle(4'b1000, a, b);
      idle(10);

      for (int i = 0; i < 300; i++) rnd_cycle(4'($urandom_range(0, 15)));
      idle(20);
      chk("drain_busy", 64'(bus_if.o_busy), 64'd0);
      chk("drain_sb_empty", 64'(sb.size()), 64'd0);

      // reset with three operations in flight
      for (int i = 0; i < 3; i++) rnd_cycle(4'b1111);
      idle(3);
      bus_if.i_req_valid = '1;
      i_rst_n = 1'b0;
      #1;
      chk("midrst_ready", 64'(bus_if.o_req_ready), 64'd0);
      chk("midrst_rsp_valid", 64'(bus_if.o_rsp_valid), 64'd0);
      chk("midrst_rsp_id", 64'(bus_if.o_rsp_id), 64'd0);
      chk("midrst_rsp_sum", 64'(bus_if.o_rsp_sum), 64'd0);
      chk("midrst_busy", 64'(bus_if.o_busy), 64'd0);
      sb.delete();
      for (int k = 0; k < N; k++) due_q[k].delete();
      last = N - 1;
      @(posedge i_clk);
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      idle(10);
      rnd_cycle(4'b1111);
      idle(12);
      chk("final_busy", 64'(bus_if.o_busy), 64'd0);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
